// File: rtl/xor_crypt_pkg.sv
// Shared types and constants for the repeating-key XOR stream engine.
package xor_crypt_pkg;
    localparam int KEY_BYTES_DEF = 16;
    localparam int KEY_AW        = $clog2(KEY_BYTES_DEF);
    localparam int BYTE_W        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/xor_8.sv
// 8-bit XOR cell: y = a ^ b, purely combinational.
module xor_8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] y_o
);
    assign y_o = a_i ^ b_i;
endmodule

// File: rtl/xor_key_bank.sv
// Key register file with write port, wrapping key index and read mux.
// The index restarts at 0 on load and wraps after reaching the latched key length.
module xor_key_bank
    import xor_crypt_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int AW        = $clog2(KEY_BYTES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              load_i,
    input  logic [AW-1:0]     klen_i,
    input  logic              adv_i,
    output logic [BYTE_W-1:0] key_o
);
    logic [BYTE_W-1:0] key_q [KEY_BYTES];
    logic [AW-1:0]     idx_q;
    logic [AW-1:0]     klen_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < KEY_BYTES; i++) begin
                key_q[i] <= '0;
            end
            idx_q  <= '0;
            klen_q <= '0;
        end else begin
            if (wr_en_i) begin
                key_q[wr_addr_i] <= wr_data_i;
            end
            if (load_i) begin
                klen_q <= klen_i;
                idx_q  <= '0;
            end else if (adv_i) begin
                idx_q <= (idx_q == klen_q) ? '0 : idx_q + AW'(1);
            end
        end
    end

    assign key_o = key_q[idx_q];
endmodule

// File: rtl/xor_stream_ctrl.sv
// Repeating-key XOR stream controller: IDLE/RUN/DRAIN FSM, length counter, registered output.
// Optional build macro XOR_CHAIN_EN adds output chaining and the DECRYPT port.
module xor_stream_ctrl
    import xor_crypt_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int LEN_W     = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         KEY_WR,
    input  logic [$clog2(KEY_BYTES)-1:0] KEY_ADDR,
    input  logic [7:0]                   KEY_DATA,
    input  logic [$clog2(KEY_BYTES)-1:0] KEY_LEN_M1,
    input  logic                         START,
    input  logic [LEN_W-1:0]             MSG_LEN,
`ifdef XOR_CHAIN_EN
    input  logic                         DECRYPT,
`endif
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [7:0]                   IN_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [7:0]                   OUT_DATA,
    output logic                         OUT_LAST,
    output logic                         BUSY,
    output logic                         DONE
);
    localparam int AW = $clog2(KEY_BYTES);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              out_vld_q, out_vld_d;
    logic [BYTE_W-1:0] out_dat_q, out_dat_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              in_rdy, busy;
    logic [BYTE_W-1:0] key_byte, mix_key, xor_res;

    wire start_ok  = (state_q == IDLE) && START;
    wire start_run = start_ok && (MSG_LEN != '0);
    wire accept    = IN_VALID && in_rdy;
    wire out_hs    = out_vld_q && OUT_READY;
    wire last_in   = (remaining_q == LEN_W'(1));

    // Key writes are gated to IDLE so the bank is frozen for a running message.
    xor_key_bank #(
        .KEY_BYTES (KEY_BYTES),
        .AW        (AW)
    ) u_key_bank (
        .clk_i     (CLK),
        .rst_i     (RST),
        .wr_en_i   (KEY_WR && (state_q == IDLE)),
        .wr_addr_i (KEY_ADDR),
        .wr_data_i (KEY_DATA),
        .load_i    (start_run),
        .klen_i    (KEY_LEN_M1),
        .adv_i     (accept),
        .key_o     (key_byte)
    );

`ifdef XOR_CHAIN_EN
    logic [BYTE_W-1:0] chain_q, chain_d;
    logic              decrypt_q, decrypt_d;

    always_comb begin
        chain_d   = chain_q;
        decrypt_d = decrypt_q;
        if (start_ok) begin
            chain_d   = '0;
            decrypt_d = DECRYPT;
        end else if (accept) begin
            chain_d = decrypt_q ? IN_DATA : xor_res;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            chain_q   <= '0;
            decrypt_q <= 1'b0;
        end else begin
            chain_q   <= chain_d;
            decrypt_q <= decrypt_d;
        end
    end

    assign mix_key = key_byte ^ chain_q;
`else
    assign mix_key = key_byte;
`endif

    xor_8 u_xor (
        .a_i (IN_DATA),
        .b_i (mix_key),
        .y_o (xor_res)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_run) state_d = RUN;
            RUN:     if (accept && last_in) state_d = DRAIN;
            DRAIN:   if (out_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_rdy = (state_q == RUN) && (!out_vld_q || OUT_READY);
        busy   = (state_q != IDLE);
    end

    always_comb begin
        remaining_d = remaining_q;
        out_vld_d   = out_vld_q;
        out_dat_d   = out_dat_q;
        out_last_d  = out_last_q;
        if (start_run) begin
            remaining_d = MSG_LEN;
        end else if (accept) begin
            remaining_d = remaining_q - LEN_W'(1);
        end
        if (accept) begin
            out_vld_d  = 1'b1;
            out_dat_d  = xor_res;
            out_last_d = last_in;
        end else if (out_hs) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
        end
        done_d = (start_ok && (MSG_LEN == '0)) || ((state_q == DRAIN) && out_hs);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            remaining_q <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign IN_READY  = in_rdy;
    assign BUSY      = busy;
    assign OUT_VALID = out_vld_q;
    assign OUT_DATA  = out_dat_q;
    assign OUT_LAST  = out_last_q;
    assign DONE      = done_q;
endmodule
